// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: per-side cache-miss FSMs, deferred jump flush,
// optional IF/ID bubble on instruction misses and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int unsigned NSTAGES         = 5,
    parameter int unsigned DMEM_STAGE      = 2,
    parameter int unsigned FLUSH_DEPTH     = 2,
    parameter bit          BUBBLE_ON_IMISS = 1'b1,
    parameter int unsigned CNT_W           = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               imiss,
    input  logic               ifill,
    input  logic               dmiss,
    input  logic               dfill,
    input  logic               jump,
    input  logic               clr_cnt,
    output logic               pc_we,
    output logic [NSTAGES-1:0] stage_we,
    output logic [NSTAGES-1:0] stage_flush,
    output logic               busy,
    output logic [CNT_W-1:0]   stall_cnt
);

    typedef enum logic [1:0] {I_RUN, I_MISS, I_FILL} i_state_t;
    typedef enum logic [1:0] {D_RUN, D_MISS, D_FILL} d_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    i_state_t i_state, i_next;
    d_state_t d_state, d_next;
    logic     jump_pend, jump_pend_next;
    logic     i_hold, d_hold, jump_req;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_state   <= I_RUN;
            d_state   <= D_RUN;
            jump_pend <= 1'b0;
        end else begin
            i_state   <= i_next;
            d_state   <= d_next;
            jump_pend <= jump_pend_next;
        end
    end

    // Next-state and combinational stall/flush decode
    always_comb begin
        i_next         = i_state;
        d_next         = d_state;
        jump_pend_next = jump_pend;
        pc_we          = 1'b1;
        stage_we       = '1;
        stage_flush    = '0;
        i_hold         = 1'b0;
        d_hold         = 1'b0;
        jump_req       = jump | jump_pend;

        // FILL ignores a miss: the cache may still report the stale one for a cycle
        case (i_state)
            I_RUN:   if (imiss) i_next = I_MISS;
            I_MISS:  if (ifill) i_next = I_FILL;
            I_FILL:  i_next = I_RUN;
            default: i_next = I_RUN;
        endcase

        case (d_state)
            D_RUN:   if (dmiss) d_next = D_MISS;
            D_MISS:  if (dfill) d_next = D_FILL;
            D_FILL:  d_next = D_RUN;
            default: d_next = D_RUN;
        endcase

        i_hold = ((i_state == I_RUN) && imiss) || (i_state == I_MISS);
        d_hold = ((d_state == D_RUN) && dmiss) || (d_state == D_MISS);

        if (d_hold) begin
            pc_we = 1'b0;
            for (int unsigned i = 0; i < NSTAGES; i++) begin
                if (i <= DMEM_STAGE) stage_we[i] = 1'b0;
            end
        end else if (i_hold) begin
            pc_we = 1'b0;
            if (BUBBLE_ON_IMISS) begin
                stage_we[0]    = 1'b1;
                stage_flush[0] = 1'b1;
            end else begin
                stage_we[0] = 1'b0;
            end
        end else if (jump_req) begin
            for (int unsigned i = 0; i < NSTAGES; i++) begin
                if (i < FLUSH_DEPTH) stage_flush[i] = 1'b1;
            end
        end

        // A jump blocked by a hold waits; it is consumed the cycle it flushes
        jump_pend_next = (d_hold || i_hold) ? jump_req : 1'b0;
    end

    assign busy = (i_state != I_RUN) || (d_state != D_RUN);

    // Saturating count of cycles with the PC frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt <= '0;
        end else if (!pc_we && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed, table-driven bench for pipe_hazard_ctrl (CNT_W=4 so saturation is reachable).
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       imiss, ifill, dmiss, dfill, jump, clr_cnt;
    logic       pc_we;
    logic [4:0] stage_we;
    logic [4:0] stage_flush;
    logic       busy;
    logic [3:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(
        .NSTAGES(5), .DMEM_STAGE(2), .FLUSH_DEPTH(2), .BUBBLE_ON_IMISS(1'b1), .CNT_W(4)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imiss(imiss), .ifill(ifill), .dmiss(dmiss), .dfill(dfill),
        .jump(jump), .clr_cnt(clr_cnt),
        .pc_we(pc_we), .stage_we(stage_we), .stage_flush(stage_flush),
        .busy(busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       imiss, ifill, dmiss, dfill, jump, clr;
        logic       pc;
        logic [4:0] we;
        logic [4:0] fl;
        logic       busy;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [5:0] in, input logic pc, input logic [4:0] we,
                                input logic [4:0] fl, input logic bz, input logic [3:0] cnt);
        vec_t v;
        {v.imiss, v.ifill, v.dmiss, v.dfill, v.jump, v.clr} = in;
        v.pc = pc; v.we = we; v.fl = fl; v.busy = bz; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic pc, input logic [4:0] we, input logic [4:0] fl,
                           input logic bz, input logic [3:0] cnt);
        chk("pc_we", idx, 32'(pc_we), 32'(pc));
        chk("stage_we", idx, 32'(stage_we), 32'(we));
        chk("stage_flush", idx, 32'(stage_flush), 32'(fl));
        chk("busy", idx, 32'(busy), 32'(bz));
        chk("stall_cnt", idx, 32'(stall_cnt), 32'(cnt));
    endtask

    // Inputs change just after negedge; combinational outputs are sampled 1 ns later
    task automatic drive(input logic [5:0] in);
        @(negedge clk);
        {imiss, ifill, dmiss, dfill, jump, clr_cnt} = in;
        #1;
    endtask

    // Input order in vectors: {imiss, ifill, dmiss, dfill, jump, clr}
    initial begin
        // I-miss at 2, ifill at 6, imiss still high through 7 (stale miss in FILL)
        vecs.push_back(mk(6'b000000, 1, 5'b11111, 5'b00000, 0, 0));
        vecs.push_back(mk(6'b000000, 1, 5'b11111, 5'b00000, 0, 0));
        vecs.push_back(mk(6'b100000, 0, 5'b11111, 5'b00001, 0, 0));
        vecs.push_back(mk(6'b100000, 0, 5'b11111, 5'b00001, 1, 1));
        vecs.push_back(mk(6'b100000, 0, 5'b11111, 5'b00001, 1, 2));
        vecs.push_back(mk(6'b100000, 0, 5'b11111, 5'b00001, 1, 3));
        vecs.push_back(mk(6'b110000, 0, 5'b11111, 5'b00001, 1, 4));
        vecs.push_back(mk(6'b100000, 1, 5'b11111, 5'b00000, 1, 5));
        vecs.push_back(mk(6'b000000, 1, 5'b11111, 5'b00000, 0, 5));
        // D-miss at b3, dfill at b8, counter cleared first
        vecs.push_back(mk(6'b000001, 1, 5'b11111, 5'b00000, 0, 5));
        vecs.push_back(mk(6'b000000, 1, 5'b11111, 5'b00000, 0, 0));
        vecs.push_back(mk(6'b000000, 1, 5'b11111, 5'b00000, 0, 0));
        vecs.push_back(mk(6'b001000, 0, 5'b11000, 5'b00000, 0, 0));
        vecs.push_back(mk(6'b000000, 0, 5'b11000, 5'b00000, 1, 1));
        vecs.push_back(mk(6'b000000, 0, 5'b11000, 5'b00000, 1, 2));
        vecs.push_back(mk(6'b000000, 0, 5'b11000, 5'b00000, 1, 3));
        vecs.push_back(mk(6'b000000, 0, 5'b11000, 5'b00000, 1, 4));
        vecs.push_back(mk(6'b000100, 0, 5'b11000, 5'b00000, 1, 5));
        vecs.push_back(mk(6'b000000, 1, 5'b11111, 5'b00000, 1, 6));
        vecs.push_back(mk(6'b000000, 1, 5'b11111, 5'b00000, 0, 6));
        // Immediate jump, then jump deferred by a D-miss
        vecs.push_back(mk(6'b000010, 1, 5'b11111, 5'b00011, 0, 6));
        vecs.push_back(mk(6'b000000, 1, 5'b11111, 5'b00000, 0, 6));
        vecs.push_back(mk(6'b001000, 0, 5'b11000, 5'b00000, 0, 6));
        vecs.push_back(mk(6'b000010, 0, 5'b11000, 5'b00000, 1, 7));
        vecs.push_back(mk(6'b000000, 0, 5'b11000, 5'b00000, 1, 8));
        vecs.push_back(mk(6'b000100, 0, 5'b11000, 5'b00000, 1, 9));
        vecs.push_back(mk(6'b000000, 1, 5'b11111, 5'b00011, 1, 10));
        vecs.push_back(mk(6'b000000, 1, 5'b11111, 5'b00000, 0, 10));
        // Simultaneous misses, D released first, then I-only behaviour, counter saturates
        vecs.push_back(mk(6'b101000, 0, 5'b11000, 5'b00000, 0, 10));
        vecs.push_back(mk(6'b000000, 0, 5'b11000, 5'b00000, 1, 11));
        vecs.push_back(mk(6'b000100, 0, 5'b11000, 5'b00000, 1, 12));
        vecs.push_back(mk(6'b000000, 0, 5'b11111, 5'b00001, 1, 13));
        vecs.push_back(mk(6'b010000, 0, 5'b11111, 5'b00001, 1, 14));
        vecs.push_back(mk(6'b000000, 1, 5'b11111, 5'b00000, 1, 15));
        vecs.push_back(mk(6'b000000, 1, 5'b11111, 5'b00000, 0, 15));
        // Fill pulses without a preceding miss are ignored
        vecs.push_back(mk(6'b010100, 1, 5'b11111, 5'b00000, 0, 15));
        vecs.push_back(mk(6'b000000, 1, 5'b11111, 5'b00000, 0, 15));

        rst_n = 1'b0;
        {imiss, ifill, dmiss, dfill, jump, clr_cnt} = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all(-1, 1'b1, 5'b11111, 5'b00000, 1'b0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_all(0, 1'b1, 5'b11111, 5'b00000, 1'b0, 4'd0);

        foreach (vecs[i]) begin
            drive({vecs[i].imiss, vecs[i].ifill, vecs[i].dmiss, vecs[i].dfill, vecs[i].jump, vecs[i].clr});
            chk_all(i, vecs[i].pc, vecs[i].we, vecs[i].fl, vecs[i].busy, vecs[i].cnt);
        end

        // Saturation: clear, hold dmiss 20 cycles, clear mid-stall, resume, release
        drive(6'b000001);
        drive(6'b001000);
        chk("sat_start", 0, 32'(stall_cnt), 32'd0);
        repeat (19) drive(6'b001000);
        drive(6'b001000);
        chk("sat_value", 0, 32'(stall_cnt), 32'd15);
        chk("sat_pc_we", 0, 32'(pc_we), 32'd0);
        drive(6'b001001);
        drive(6'b001000);
        chk("sat_clear", 0, 32'(stall_cnt), 32'd0);
        drive(6'b001100);
        chk("sat_resume", 0, 32'(stall_cnt), 32'd1);
        drive(6'b000000);
        chk("sat_release_pc", 0, 32'(pc_we), 32'd1);
        chk("sat_after_fill", 0, 32'(stall_cnt), 32'd2);
        drive(6'b000000);

        // Reset mid-miss with a pending jump: FSMs to RUN, pending flush dropped
        drive(6'b001000);
        drive(6'b000010);
        drive(6'b000000);
        chk("rst_pre_busy", 0, 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 0, 32'(busy), 32'd0);
        chk("rst_pc_we", 0, 32'(pc_we), 32'd1);
        chk("rst_cnt", 0, 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(6'b000000);
        chk("rst_no_flush", 0, 32'(stage_flush), 32'd0);
        chk("rst_we", 0, 32'(stage_we), 32'h1f);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline stall/flush controller for the MIPS core. It generalises the cache-miss stall logic to N pipeline registers and a configurable data-cache stage. It adds per-side miss state machines, deferred jump flushes, optional bubble injection on instruction misses, and a saturating stall-cycle counter. It sits beside the datapath and drives the PC write enable plus one write-enable/flush pair per pipeline register.

## Interface
- NSTAGES, 5, number of pipeline registers; index 0 = IF/ID, increasing downstream
- DMEM_STAGE, 2, highest register index held on a data miss (registers 0..DMEM_STAGE hold; higher indices keep writing)
- FLUSH_DEPTH, 2, jump flushes registers 0..FLUSH_DEPTH-1 (1 ≤ FLUSH_DEPTH ≤ NSTAGES)
- BUBBLE_ON_IMISS, 1, 1: IF/ID is loaded with a bubble during an I-miss; 0: IF/ID holds
- CNT_W, 16, stall counter width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- imiss  in  1  instruction cache miss
- ifill  in  1  instruction cache line fill complete (1-cycle pulse)
- dmiss  in  1  data cache miss
- dfill  in  1  data cache line fill complete (1-cycle pulse)
- jump  in  1  taken branch/jump redirect request
- clr_cnt  in  1  synchronous clear of stall_cnt
- pc_we  out  1  PC write enable
- stage_we  out  NSTAGES  per-register write enable
- stage_flush  out  NSTAGES  per-register synchronous clear; overrides stage_we in the datapath
- busy  out  1  either miss FSM not in RUN
- stall_cnt  out  CNT_W  cycles with pc_we=0, saturating

## Operation
- I-side FSM, states I_RUN, I_MISS, I_FILL:
  - I_RUN -> I_MISS on imiss.
  - I_MISS -> I_FILL on ifill.
  - I_FILL -> I_RUN unconditionally. imiss is ignored in I_FILL because the cache may still report the stale miss for one cycle.
- D-side FSM: identical shape (D_RUN, D_MISS, D_FILL) on dmiss/dfill.
- i_hold = (I_RUN & imiss) | I_MISS; d_hold = (D_RUN & dmiss) | D_MISS. Both are combinational, so the stall takes effect in the same cycle as the miss.
- d_hold:
  - pc_we=0.
  - stage_we[0..DMEM_STAGE]=0.
  - Higher stages keep writing.
  - d_hold dominates all other requests.
- i_hold without d_hold:
  - pc_we=0.
  - If BUBBLE_ON_IMISS: stage_we[0]=1 and stage_flush[0]=1.
  - Otherwise: stage_we[0]=0.
  - Stages 1.. keep writing.
- Jump:
  - Applied when jump (or jump_pend) is set and neither hold is active: stage_flush[0..FLUSH_DEPTH-1]=1, pc_we=1.
  - If either hold is active, jump_pend is set instead.
  - jump_pend is cleared on the cycle the flush is applied.
  - A new jump while jump_pend is set merges into the same pending flag.
  - The datapath holds the jump target while jump_pend is set.
- Default, no events: pc_we=1, stage_we all 1, stage_flush all 0.
- stall_cnt:
  - +1 on each cycle with pc_we=0.
  - Saturates at 2^CNT_W-1.
  - clr_cnt takes priority over increment.
- busy = !I_RUN | !D_RUN.

## Timing
- Reset (rst_n low, asynchronous): both FSMs in RUN, jump_pend=0, stall_cnt=0. With inputs low this gives pc_we=1, stage_we all 1, stage_flush 0, busy=0.
- Miss to stall: 0 cycles (combinational).
- Release after fill: fill pulse at edge k moves the FSM to FILL, so the hold drops in cycle k+1. The FSM returns to RUN at k+2.
- Deferred jump: flush is asserted in the first cycle both holds are low.
- dmiss and imiss in the same cycle: both FSMs advance independently; d_hold outputs apply.
- dfill while I_MISS: D-stages release, pc_we stays 0, and the IF/ID behaviour follows the i_hold-only rule.
- ifill without a preceding imiss (FSM in I_RUN): ignored. dfill likewise.
- rst_n asserted mid-miss: FSMs return to RUN and jump_pend is dropped immediately. The cache must be reset too.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release -> pc_we=1, stage_we=5'b11111, stage_flush=0, stall_cnt=0, busy=0.
- I-miss with defaults: imiss high at cycle 2, ifill at cycle 6 ->
  - pc_we=0 in cycles 2..6 and 1 from cycle 7;
  - stage_flush[0]=1 in cycles 2..6;
  - stall_cnt=5.
- D-miss with DMEM_STAGE=2: dmiss at cycle 3, dfill at cycle 8 ->
  - stage_we=5'b11000 in cycles 3..8;
  - pc_we=0 in cycles 3..8;
  - stage_we all 1 at cycle 9.
- Jump during D-miss: dmiss at cycle 1, jump pulse at cycle 2, dfill at cycle 4 ->
  - no flush before cycle 5;
  - stage_flush=5'b00011 and pc_we=1 at cycle 5 only.
- Stale miss in FILL: imiss held high through the ifill cycle and one cycle after -> FSM does not re-enter I_MISS, pc_we=1 in the cycle after ifill.
- Counter: CNT_W=4, dmiss held for 20 cycles -> stall_cnt saturates at 15; clr_cnt pulse during the stall -> 0 the next cycle, then counting resumes.
